// File: rtl/cube_pkg.sv
// Shared cube definitions: geometry, cell indexing, display scan states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Used by the display driver, the Conway simulator and the setup/editor logic.
package cube_pkg;

  localparam int N_SIDE     = 8;
  localparam int N_CELLS    = 512;
  localparam int LAYER_BITS = 64;

  // Display scan sequencer states.
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_HOLD  = 2'd3
  } disp_state_t;

  // Flat cell index: z selects the layer, y the row, x the column.
  function automatic int unsigned idx(input int unsigned x,
                                      input int unsigned y,
                                      input int unsigned z);
    return z * 64 + y * 8 + x;
  endfunction

  // Bits needed for a counter running 0 .. max(a, b) - 1 (at least 1 bit).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cube_display_driver_if.sv
// Bundle between the cell source / LED cube hardware and the display driver.
// Latency: n/a (wiring only).
// Backpressure: none; Cells_valid is a level, display outputs are free-running.
// Ports: Cells/Cells_valid flow into the driver; Frame_taken, SR_data, SR_clk,
// SR_latch, Layer_en and Frame_done flow out. The driver uses the slave modport.
interface cube_display_driver_if;
  import cube_pkg::*;

  logic [N_CELLS-1:0] Cells;
  logic               Cells_valid;
  logic               Frame_taken;
  logic               SR_data;
  logic               SR_clk;
  logic               SR_latch;
  logic [N_SIDE-1:0]  Layer_en;
  logic               Frame_done;

  modport master (
    output Cells, Cells_valid,
    input  Frame_taken, SR_data, SR_clk, SR_latch, Layer_en, Frame_done
  );

  modport slave (
    input  Cells, Cells_valid,
    output Frame_taken, SR_data, SR_clk, SR_latch, Layer_en, Frame_done
  );

endinterface

// File: rtl/cube_display_driver_layer_serializer.sv
// 64-bit parallel-load PISO, MSB first, with a divided shift clock.
// Latency: first bit on SR_data the cycle after load; 128*CLK_DIV cycles total.
// Backpressure: none; a load restarts the shift unconditionally.
// Ports: Clk, Reset (async, high); load + data[63:0] in; SR_data, SR_clk out;
// done pulses on the last cycle of bit 0's high phase.
module layer_serializer
  import cube_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CNT_W   = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  load,
  input  logic [LAYER_BITS-1:0] data,
  output logic                  SR_data,
  output logic                  SR_clk,
  output logic                  done
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  logic [LAYER_BITS-1:0] shreg;
  logic [5:0]            bit_cnt;
  logic [CNT_W-1:0]      div_cnt;
  logic                  phase;   // 0 = SR_clk low half, 1 = high half
  logic                  active;
  logic                  half_end;

  assign half_end = active && (div_cnt == DIV_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shreg   <= '0;
      bit_cnt <= 6'd63;
      div_cnt <= '0;
      phase   <= 1'b0;
      active  <= 1'b0;
    end else if (load) begin
      shreg   <= data;
      bit_cnt <= 6'd63;
      div_cnt <= '0;
      phase   <= 1'b0;
      active  <= 1'b1;
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!phase) begin
          phase <= 1'b1;
        end else begin
          // Data only advances at the end of the high half, so it is
          // already stable before the next rising edge.
          phase <= 1'b0;
          shreg <= {shreg[LAYER_BITS-2:0], 1'b0};
          if (bit_cnt == 6'd0) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

  assign SR_data = active & shreg[LAYER_BITS-1];
  assign SR_clk  = active & phase;
  assign done    = half_end & phase & (bit_cnt == 6'd0);

endmodule

// File: rtl/cube_display_driver.sv
// Scans the 8x8x8 LED cube layer by layer from a tear-free shadow frame buffer.
// Latency: layer = 1 + 128*CLK_DIV + 1 + LAYER_HOLD cycles; frame = 8 layers.
// Backpressure: none; Cells is sampled only at the layer-0 START, else ignored.
// Ports: Clk, Reset (async, active-high); bus (slave) carries Cells/Cells_valid
// in and Frame_taken, SR_data, SR_clk, SR_latch, Layer_en, Frame_done out.
module cube_display_driver
  import cube_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int LAYER_HOLD = 64
) (
  input  logic                  Clk,
  input  logic                  Reset,
  cube_display_driver_if.slave  bus
);

  localparam int               CNT_W     = cnt_width(CLK_DIV, LAYER_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LAYER_HOLD - 1);

  disp_state_t           state, state_nx;
  logic [N_CELLS-1:0]    frame_buf;
  logic [2:0]            z;
  logic [CNT_W-1:0]      hold_cnt;
  logic                  hold_last;
  logic                  capture;
  logic                  ser_load;
  logic                  ser_done;
  logic [LAYER_BITS-1:0] layer_dat;

  logic                  latch_c;
  logic                  frame_done_c;
  logic [N_SIDE-1:0]     layer_en_c;

  // Reset gates the capture strobe so Frame_taken stays low while Reset is
  // held, even though the held state already looks like a layer-0 START.
  assign capture  = (state == ST_START) && (z == 3'd0) && bus.Cells_valid && !Reset;
  assign ser_load = (state == ST_START);

  // On a capture cycle the buffer is only written at the clock edge, so layer 0
  // has to be fed straight from Cells to show the new generation immediately.
  assign layer_dat = capture ? bus.Cells[LAYER_BITS-1:0]
                             : frame_buf[{z, 6'd0} +: LAYER_BITS];

  assign hold_last = (hold_cnt == HOLD_LAST);

  layer_serializer #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_ser (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (ser_load),
    .data    (layer_dat),
    .SR_data (bus.SR_data),
    .SR_clk  (bus.SR_clk),
    .done    (ser_done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_START;
      frame_buf <= '0;
      z         <= 3'd0;
      hold_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        frame_buf <= bus.Cells;
      end
      if (state == ST_HOLD) begin
        if (hold_last) begin
          hold_cnt <= '0;
          z        <= z + 3'd1;  // 7 wraps to 0 for the next frame
        end else begin
          hold_cnt <= hold_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_nx     = state;
    latch_c      = 1'b0;
    frame_done_c = 1'b0;
    layer_en_c   = '0;
    case (state)
      ST_START: begin
        state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ser_done) begin
          state_nx = ST_LATCH;
        end
      end
      ST_LATCH: begin
        latch_c  = 1'b1;
        state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        layer_en_c[z] = 1'b1;
        if (hold_last) begin
          frame_done_c = (z == 3'd7);
          state_nx     = ST_START;
        end
      end
      default: begin
        state_nx = ST_START;
      end
    endcase
  end

  assign bus.Frame_taken = capture;
  assign bus.SR_latch    = latch_c;
  assign bus.Layer_en    = layer_en_c;
  assign bus.Frame_done  = frame_done_c;

endmodule

// File: tb/tb_cube_display_driver.sv
// Directed bench for cube_display_driver: small-parameter scan checks plus a
// default-parameter frame-period run on a second instance.
module tb_cube_display_driver;
  import cube_pkg::*;

  logic Clk;
  logic Reset;
  logic Reset2;

  cube_display_driver_if bus1();
  cube_display_driver_if bus2();

  cube_display_driver #(.CLK_DIV(1), .LAYER_HOLD(4)) dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus1)
  );

  cube_display_driver dut2 (
    .Clk   (Clk),
    .Reset (Reset2),
    .bus   (bus2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cyc;

  logic [511:0] frame_zero;
  logic [511:0] frame_a;
  logic [511:0] frame_b;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Entry: just after the falling edge inside a START cycle of layer zz
  // (CLK_DIV=1, LAYER_HOLD=4). Exit: falling edge of the next START cycle.
  // Cycle map: 0 START, 1..128 SHIFT (odd low, even high), 129 LATCH, 130..133 HOLD.
  task automatic run_layer(input int zz, input logic [63:0] exp_bits, input int exp_taken);
    logic [63:0] got;
    logic [7:0]  exp_en;
    logic        exp_clk;
    logic        prev_clk;
    logic        prev_d;
    int rises, unstable, en_bad, clk_bad, idle_bad;
    int latch_cnt, latch_pos, taken_cnt, done_cnt;
    got = '0; prev_clk = 1'b0; prev_d = 1'b0;
    rises = 0; unstable = 0; en_bad = 0; clk_bad = 0; idle_bad = 0;
    latch_cnt = 0; latch_pos = -1; taken_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 134; c++) begin
      #1;
      if (bus1.Frame_taken) taken_cnt++;
      if (bus1.SR_latch) begin
        latch_cnt++;
        latch_pos = c;
      end
      if (bus1.Frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      exp_en = (c >= 130) ? (8'd1 << zz) : 8'd0;
      if (bus1.Layer_en !== exp_en) en_bad++;
      exp_clk = (c >= 1 && c <= 128 && (c % 2) == 0);
      if (bus1.SR_clk !== exp_clk) clk_bad++;
      if (c >= 1 && c <= 128) begin
        if (bus1.SR_clk && !prev_clk) begin
          rises++;
          got = {got[62:0], bus1.SR_data};
          if (bus1.SR_data !== prev_d) unstable++;
        end
      end else if (bus1.SR_data !== 1'b0) begin
        idle_bad++;
      end
      prev_clk = bus1.SR_clk;
      prev_d   = bus1.SR_data;
      @(negedge Clk);
    end
    chk($sformatf("L%0d bits", zz), got, exp_bits);
    chk($sformatf("L%0d rises", zz), 64'(rises), 64'd64);
    chk($sformatf("L%0d data_stable", zz), 64'(unstable), 64'd0);
    chk($sformatf("L%0d clk_shape", zz), 64'(clk_bad), 64'd0);
    chk($sformatf("L%0d data_idle", zz), 64'(idle_bad), 64'd0);
    chk($sformatf("L%0d layer_en", zz), 64'(en_bad), 64'd0);
    chk($sformatf("L%0d latch_cnt", zz), 64'(latch_cnt), 64'd1);
    chk($sformatf("L%0d latch_pos", zz), 64'(latch_pos), 64'd129);
    chk($sformatf("L%0d taken", zz), 64'(taken_cnt), 64'(exp_taken));
    chk($sformatf("L%0d frame_done", zz), 64'(done_cnt), (zz == 7) ? 64'd1 : 64'd0);
  endtask

  task automatic run_frame(input logic [511:0] f, input int taken0);
    for (int zz = 0; zz < 8; zz++) begin
      run_layer(zz, f[zz*64 +: 64], (zz == 0) ? taken0 : 0);
    end
  endtask

  initial begin
    int c0, d1, d2, ones, taken2, budget;

    Reset = 1'b1;
    Reset2 = 1'b1;
    bus1.Cells = '0;
    bus1.Cells_valid = 1'b0;
    bus2.Cells = '0;
    bus2.Cells_valid = 1'b0;
    done_cyc = -1;

    frame_zero = '0;
    frame_a = '0;
    frame_a[171] = 1'b1;       // x=3, y=5, z=2 -> 2*64 + 5*8 + 3
    frame_b = '0;
    frame_b[9] = 1'b1;         // x=1, y=1, z=0
    frame_b[511] = 1'b1;       // x=7, y=7, z=7

    // Reset state, with Cells_valid high to prove capture is blocked.
    repeat (3) @(negedge Clk);
    bus1.Cells = '1;
    bus1.Cells_valid = 1'b1;
    #1;
    chk("rst layer_en", 64'(bus1.Layer_en), 64'd0);
    chk("rst sr_data", 64'(bus1.SR_data), 64'd0);
    chk("rst sr_clk", 64'(bus1.SR_clk), 64'd0);
    chk("rst sr_latch", 64'(bus1.SR_latch), 64'd0);
    chk("rst frame_done", 64'(bus1.Frame_done), 64'd0);
    chk("rst frame_taken", 64'(bus1.Frame_taken), 64'd0);
    bus1.Cells = '0;
    bus1.Cells_valid = 1'b0;
    @(negedge Clk);

    // Empty frame after release: zeros everywhere, no capture.
    Reset = 1'b0;
    c0 = cyc;
    run_frame(frame_zero, 0);
    chk("frame1 length", 64'(done_cyc - c0 + 1), 64'd1072);

    // Single lit cell, valid pulsed only around the layer-0 START.
    bus1.Cells = frame_a;
    bus1.Cells_valid = 1'b1;
    run_layer(0, frame_a[63:0], 1);
    bus1.Cells_valid = 1'b0;
    for (int zz = 1; zz < 8; zz++) run_layer(zz, frame_a[zz*64 +: 64], 0);
    chk("A layer2 slice", frame_a[128 +: 64], 64'h0000_0800_0000_0000);

    // New generation offered mid-frame must wait for the next frame boundary.
    for (int zz = 0; zz < 3; zz++) run_layer(zz, frame_a[zz*64 +: 64], 0);
    bus1.Cells = frame_b;
    bus1.Cells_valid = 1'b1;
    for (int zz = 3; zz < 8; zz++) run_layer(zz, frame_a[zz*64 +: 64], 0);
    run_frame(frame_b, 1);
    // Valid held high: recapture at the following frame too.
    for (int zz = 0; zz < 5; zz++) run_layer(zz, frame_b[zz*64 +: 64], (zz == 0) ? 1 : 0);

    // Reset during layer 5 HOLD: outputs drop without waiting for a clock.
    repeat (131) @(negedge Clk);
    #1;
    chk("hold5 layer_en", 64'(bus1.Layer_en), 64'h20);
    #2;
    Reset = 1'b1;
    #1;
    chk("async layer_en", 64'(bus1.Layer_en), 64'd0);
    chk("async sr_data", 64'(bus1.SR_data), 64'd0);
    chk("async sr_clk", 64'(bus1.SR_clk), 64'd0);
    chk("async sr_latch", 64'(bus1.SR_latch), 64'd0);
    chk("async frame_taken", 64'(bus1.Frame_taken), 64'd0);
    bus1.Cells_valid = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    c0 = cyc;
    run_frame(frame_zero, 0);
    chk("post-rst length", 64'(done_cyc - c0 + 1), 64'd1072);

    // Default parameters, all cells lit.
    @(negedge Clk);
    bus2.Cells = '1;
    bus2.Cells_valid = 1'b1;
    Reset2 = 1'b0;
    c0 = cyc;
    d1 = -1; d2 = -1; ones = 0; taken2 = 0; budget = 0;
    while (d2 < 0 && budget < 8000) begin
      #1;
      if (d1 >= 0) begin
        if (bus2.SR_data) ones++;
        if (bus2.Frame_taken) taken2++;
      end
      if (bus2.Frame_done) begin
        if (d1 < 0) d1 = cyc;
        else d2 = cyc;
      end
      budget++;
      @(negedge Clk);
    end
    chk("dflt first done", 64'(d1 - c0 + 1), 64'd2576);
    chk("dflt done period", 64'(d2 - d1), 64'd2576);
    chk("dflt ones/frame", 64'(ones), 64'd2048);
    chk("dflt taken/frame", 64'(taken2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
